// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART endpoint: register offsets,
// STATUS bit positions and the register-select decode helper.
package uart_mmio_pkg;

  localparam logic [3:0]  UART_TXDATA   = 4'h0;
  localparam logic [3:0]  UART_RXDATA   = 4'h4;
  localparam logic [3:0]  UART_STATUS   = 4'h8;

  localparam int          TX_FULL       = 0;
  localparam int          RX_EMPTY      = 1;
  localparam int          TX_OVF        = 2;
  localparam int          RX_OVF        = 3;

  localparam logic [31:0] RX_EMPTY_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_RXDATA = 2'd1,
    REG_STATUS = 2'd2,
    REG_NONE   = 2'd3
  } reg_sel_e;

  // Only word offsets are decoded; the byte lane bits are ignored.
  function automatic reg_sel_e decode_reg(input logic [3:0] addr);
    reg_sel_e sel;
    case ({addr[3:2], 2'b00})
      UART_TXDATA: sel = REG_TXDATA;
      UART_RXDATA: sel = REG_RXDATA;
      UART_STATUS: sel = REG_STATUS;
      default:     sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_mmio_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count     = wr_ptr_r - rd_ptr_r;
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write
  always_ff @(posedge clock) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART endpoint: bus register decode, TX FIFO drained onto the
// 9-bit output strobe with optional pacing, RX FIFO filled from the input strobe.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int TX_GAP   = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bus_valid,
  input  logic        bus_write,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  input  logic [8:0]  uart_data_in,
  output logic [8:0]  uart_data_out,
  output logic        rx_irq
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int GAP_W = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(TX_GAP);

  logic             bus_ready_r;
  logic [31:0]      bus_rdata_r;
  logic [8:0]       uart_data_out_r;
  logic             rx_irq_r;
  logic             tx_ovf_r;
  logic             rx_ovf_r;
  logic [GAP_W-1:0] gap_cnt_r;

  reg_sel_e         sel_s;
  logic             accept_s;
  logic             status_wr_s;
  logic             tx_push_s;
  logic             tx_pop_s;
  logic             tx_drop_s;
  logic             tx_full_s;
  logic             tx_empty_s;
  logic [7:0]       tx_head_s;
  logic [TX_AW:0]   tx_count_s;
  logic             rx_push_s;
  logic             rx_push_ok_s;
  logic             rx_pop_s;
  logic             rx_drop_s;
  logic             rx_full_s;
  logic             rx_empty_s;
  logic [7:0]       rx_head_s;
  logic [RX_AW:0]   rx_count_s;
  logic [RX_AW:0]   rx_count_next_s;
  logic [31:0]      rdata_s;
  logic             unused_s;

  assign sel_s        = decode_reg(bus_addr);
  assign accept_s     = bus_valid && !bus_ready_r;
  assign status_wr_s  = accept_s && bus_write && (sel_s == REG_STATUS);
  assign tx_push_s    = accept_s && bus_write && (sel_s == REG_TXDATA);
  assign tx_pop_s     = !tx_empty_s && (gap_cnt_r == {GAP_W{1'b0}});
  assign tx_drop_s    = tx_push_s && tx_full_s && !tx_pop_s;
  assign rx_pop_s     = accept_s && !bus_write && (sel_s == REG_RXDATA) && !rx_empty_s;
  assign rx_push_s    = uart_data_in[8];
  assign rx_push_ok_s = rx_push_s && (!rx_full_s || rx_pop_s);
  assign rx_drop_s    = rx_push_s && !rx_push_ok_s;
  assign rx_count_next_s = rx_count_s + {{RX_AW{1'b0}}, rx_push_ok_s}
                                      - {{RX_AW{1'b0}}, rx_pop_s};
  assign unused_s     = ^{bus_wdata[31:8], bus_addr[1:0], tx_count_s};

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (tx_push_s),
    .pop   (tx_pop_s),
    .wdata (bus_wdata[7:0]),
    .rdata (tx_head_s),
    .full  (tx_full_s),
    .empty (tx_empty_s),
    .count (tx_count_s)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (rx_push_s),
    .pop   (rx_pop_s),
    .wdata (uart_data_in[7:0]),
    .rdata (rx_head_s),
    .full  (rx_full_s),
    .empty (rx_empty_s),
    .count (rx_count_s)
  );

  // Load data selected from the pre-edge state of the addressed register
  always_comb begin
    rdata_s = 32'h0;
    case (sel_s)
      REG_TXDATA: rdata_s = 32'h0;
      REG_RXDATA: begin
        if (rx_empty_s) rdata_s = RX_EMPTY_WORD;
        else            rdata_s = {24'h0, rx_head_s};
      end
      REG_STATUS: begin
        rdata_s[TX_FULL]  = tx_full_s;
        rdata_s[RX_EMPTY] = rx_empty_s;
        rdata_s[TX_OVF]   = tx_ovf_r;
        rdata_s[RX_OVF]   = rx_ovf_r;
      end
      default:    rdata_s = 32'h0;
    endcase
  end

  // Bus handshake and load data capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_ready_r <= 1'b0;
      bus_rdata_r <= 32'h0;
    end else begin
      bus_ready_r <= accept_s;
      if (accept_s && !bus_write) bus_rdata_r <= rdata_s;
      else                        bus_rdata_r <= 32'h0;
    end
  end

  // Sticky overflow flags; a same-edge overflow beats a write-1 clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_ovf_r <= 1'b0;
      rx_ovf_r <= 1'b0;
    end else begin
      tx_ovf_r <= tx_drop_s || (tx_ovf_r && !(status_wr_s && bus_wdata[TX_OVF]));
      rx_ovf_r <= rx_drop_s || (rx_ovf_r && !(status_wr_s && bus_wdata[RX_OVF]));
    end
  end

  // TX drain: strobe one byte per pop, then hold off for TX_GAP cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uart_data_out_r <= 9'h0;
      gap_cnt_r       <= {GAP_W{1'b0}};
    end else if (tx_pop_s) begin
      uart_data_out_r <= {1'b1, tx_head_s};
      gap_cnt_r       <= GAP_LOAD;
    end else begin
      uart_data_out_r <= {1'b0, uart_data_out_r[7:0]};
      if (gap_cnt_r != {GAP_W{1'b0}}) gap_cnt_r <= gap_cnt_r - {{(GAP_W-1){1'b0}}, 1'b1};
      else                            gap_cnt_r <= gap_cnt_r;
    end
  end

  // Interrupt follows the post-edge RX occupancy so it matches rx_empty exactly
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rx_irq_r <= 1'b0;
    else       rx_irq_r <= (rx_count_next_s != {(RX_AW+1){1'b0}});
  end

  assign bus_ready     = bus_ready_r;
  assign bus_rdata     = bus_rdata_r;
  assign uart_data_out = uart_data_out_r;
  assign rx_irq        = rx_irq_r;

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: two instances (TX_GAP 0 and 15) share all
// inputs and are compared every cycle against a queue-based reference model.
module tb_uart_mmio;

  localparam int TXD  = 8;
  localparam int RXD  = 8;
  localparam int GAP0 = 0;
  localparam int GAP1 = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        bus_valid = 1'b0;
  logic        bus_write = 1'b0;
  logic [3:0]  bus_addr = 4'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic [8:0]  uart_data_in = 9'h0;

  logic [31:0] rdata [2];
  logic        ready [2];
  logic [8:0]  dout  [2];
  logic        irq   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  uart_mmio #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .TX_GAP(GAP0)) dut0 (
    .clock(clock), .reset(reset), .bus_valid(bus_valid), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata[0]), .bus_ready(ready[0]),
    .uart_data_in(uart_data_in), .uart_data_out(dout[0]), .rx_irq(irq[0]));

  uart_mmio #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .TX_GAP(GAP1)) dut1 (
    .clock(clock), .reset(reset), .bus_valid(bus_valid), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata[1]), .bus_ready(ready[1]),
    .uart_data_in(uart_data_in), .uart_data_out(dout[1]), .rx_irq(irq[1]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte queues, a gap countdown and sticky flags per instance.
  logic [7:0]  tx_q [2][$];
  logic [7:0]  rx_q [$];
  int          gap_m [2];
  bit          tx_ovf_m [2];
  bit          rx_ovf_m;
  bit          m_ready, m_rd, acc_m;
  logic [1:0]  sel_m;
  logic [7:0]  byte_m;
  logic [8:0]  e_out [2];
  logic [31:0] e_rdata [2];
  bit          e_irq;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ready = 1'b0; m_rd = 1'b0; rx_q.delete(); rx_ovf_m = 1'b0; e_irq = 1'b0;
      for (int k = 0; k < 2; k++) begin
        tx_q[k].delete(); gap_m[k] = 0; tx_ovf_m[k] = 1'b0;
        e_out[k] = 9'h0; e_rdata[k] = 32'h0;
      end
    end else begin
      acc_m   = bus_valid && !m_ready;
      sel_m   = bus_addr[3:2];
      m_ready = acc_m;
      m_rd    = acc_m && !bus_write;
      for (int k = 0; k < 2; k++) begin
        if (sel_m == 2'd1)
          e_rdata[k] = (rx_q.size() == 0) ? 32'h8000_0000 : {24'h0, rx_q[0]};
        else if (sel_m == 2'd2)
          e_rdata[k] = {28'h0, rx_ovf_m, tx_ovf_m[k], 1'(rx_q.size() == 0), 1'(tx_q[k].size() == TXD)};
        else
          e_rdata[k] = 32'h0;
      end
      for (int k = 0; k < 2; k++) begin
        if (tx_q[k].size() > 0 && gap_m[k] == 0) begin
          byte_m   = tx_q[k].pop_front();
          e_out[k] = {1'b1, byte_m};
          gap_m[k] = (k == 0) ? GAP0 : GAP1;
        end else begin
          e_out[k][8] = 1'b0;
          if (gap_m[k] > 0) gap_m[k]--;
        end
        if (acc_m && bus_write && sel_m == 2'd2 && bus_wdata[2]) tx_ovf_m[k] = 1'b0;
        if (acc_m && bus_write && sel_m == 2'd0) begin
          if (tx_q[k].size() < TXD) tx_q[k].push_back(bus_wdata[7:0]);
          else tx_ovf_m[k] = 1'b1;
        end
      end
      if (acc_m && bus_write && sel_m == 2'd2 && bus_wdata[3]) rx_ovf_m = 1'b0;
      if (m_rd && sel_m == 2'd1 && rx_q.size() > 0) void'(rx_q.pop_front());
      if (uart_data_in[8]) begin
        if (rx_q.size() < RXD) rx_q.push_back(uart_data_in[7:0]);
        else rx_ovf_m = 1'b1;
      end
      e_irq = (rx_q.size() != 0);
    end
  end

  // Every cycle both instances are compared against the model on the falling edge
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("ready%0d", k), 32'(ready[k]), 32'(m_ready));
      check_eq($sformatf("dout%0d", k), 32'(dout[k]), 32'(e_out[k]));
      check_eq($sformatf("irq%0d", k), 32'(irq[k]), 32'(e_irq));
      if (m_ready && m_rd) check_eq($sformatf("rdata%0d", k), rdata[k], e_rdata[k]);
    end
  end

  // Called on a falling edge; returns on the falling edge of the ready cycle.
  task automatic bus_op(input bit wr, input logic [3:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd0, output logic [31:0] rd1);
    bit seen;
    seen = 1'b0;
    bus_valid = 1'b1; bus_write = wr; bus_addr = addr; bus_wdata = wd;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clock);
      seen = ready[0];
    end
    check_eq("bus_handshake", 32'(seen), 32'd1);
    rd0 = rdata[0]; rd1 = rdata[1];
    bus_valid = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    uart_data_in = {1'b1, b};
    @(negedge clock);
    uart_data_in = 9'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0, r1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_eq("idle_dout", 32'(dout[0]), 32'h0);
      check_eq("idle_ready", 32'(ready[0]), 32'h0);
      check_eq("idle_irq", 32'(irq[0]), 32'h0);
    end
    bus_op(1'b0, 4'h8, 32'h0, r0, r1);
    check_eq("reset_status0", r0, 32'h2);
    check_eq("reset_status1", r1, 32'h2);

    // Two TX bytes with no pacing
    bus_op(1'b1, 4'h0, 32'h48, r0, r1);
    check_eq("tx48_not_yet", 32'(dout[0][8]), 32'h0);
    @(negedge clock); check_eq("tx48_strobe", 32'(dout[0]), 32'h148);
    @(negedge clock); check_eq("tx48_hold", 32'(dout[0]), 32'h048);
    bus_op(1'b1, 4'h0, 32'h69, r0, r1);
    @(negedge clock); check_eq("tx69_strobe", 32'(dout[0]), 32'h169);
    @(negedge clock); check_eq("tx69_hold", 32'(dout[0]), 32'h069);
    repeat (40) @(negedge clock);

    // TX burst against the paced instance overflows its FIFO
    for (int i = 0; i < 12; i++) bus_op(1'b1, 4'h0, 32'(8'h10 + i), r0, r1);
    bus_op(1'b0, 4'h8, 32'h0, r0, r1);
    check_eq("txovf_set1", 32'(r1[2]), 32'h1);
    check_eq("txovf_clear0", 32'(r0[2]), 32'h0);
    bus_op(1'b1, 4'h8, 32'h4, r0, r1);
    bus_op(1'b0, 4'h8, 32'h0, r0, r1);
    check_eq("txovf_cleared1", 32'(r1[2]), 32'h0);
    repeat (200) @(negedge clock);
    bus_op(1'b0, 4'h8, 32'h0, r0, r1);
    check_eq("tx_drained1", r1, 32'h2);

    // Single RX byte
    rx_byte(8'h41);
    check_eq("rx_irq_rise", 32'(irq[0]), 32'h1);
    bus_op(1'b0, 4'h4, 32'h0, r0, r1);
    check_eq("rx41", r0, 32'h41);
    check_eq("rx_irq_fall", 32'(irq[0]), 32'h0);
    bus_op(1'b0, 4'h4, 32'h0, r0, r1);
    check_eq("rx_empty_word", r0, 32'h8000_0000);

    // Ten back-to-back RX bytes overflow the eight-entry FIFO
    for (int i = 0; i < 10; i++) begin
      uart_data_in = {1'b1, 8'(i)};
      @(negedge clock);
    end
    uart_data_in = 9'h0;
    bus_op(1'b0, 4'h8, 32'h0, r0, r1);
    check_eq("rxovf_status0", r0, 32'h8);
    check_eq("rxovf_status1", r1, 32'h8);
    for (int i = 0; i < 8; i++) begin
      bus_op(1'b0, 4'h4, 32'h0, r0, r1);
      check_eq($sformatf("rx_order%0d", i), r0, 32'(i));
    end
    bus_op(1'b0, 4'h4, 32'h0, r0, r1);
    check_eq("rx_drained", r0, 32'h8000_0000);

    // Full RX FIFO with a push on the same edge as a pop
    bus_op(1'b1, 4'h8, 32'h8, r0, r1);
    for (int i = 0; i < 8; i++) rx_byte(8'hA0 + 8'(i));
    bus_valid = 1'b1; bus_write = 1'b0; bus_addr = 4'h4; uart_data_in = 9'h155;
    @(negedge clock);
    uart_data_in = 9'h0;
    check_eq("pp_ready", 32'(ready[0]), 32'h1);
    check_eq("pp_oldest", rdata[0], 32'hA0);
    bus_valid = 1'b0;
    bus_op(1'b0, 4'h8, 32'h0, r0, r1);
    check_eq("pp_no_ovf", r0, 32'h0);
    for (int i = 1; i < 9; i++) begin
      bus_op(1'b0, 4'h4, 32'h0, r0, r1);
      check_eq($sformatf("pp_read%0d", i), r0, (i < 8) ? 32'(8'hA0 + i) : 32'h55);
    end

    // Randomized traffic on both sides, checked every cycle by the model
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      uart_data_in[8]   = ($urandom_range(0, 2) == 0);
      uart_data_in[7:0] = 8'($urandom);
      if (bus_valid && ready[0]) bus_valid = 1'b0;
      else if (!bus_valid && $urandom_range(0, 1) == 1) begin
        bus_valid = 1'b1;
        bus_write = 1'($urandom);
        bus_addr  = 4'($urandom);
        bus_wdata = $urandom;
      end
    end
    repeat (2) begin
      @(negedge clock);
      uart_data_in = 9'h0;
      if (bus_valid && ready[0]) bus_valid = 1'b0;
    end
    repeat (3) @(negedge clock);

    // Reset in the middle of activity clears outputs at once
    bus_op(1'b1, 4'h0, 32'h77, r0, r1);
    rx_byte(8'h11); rx_byte(8'h22);
    bus_valid = 1'b1; bus_write = 1'b0; bus_addr = 4'h4; uart_data_in = 9'h15A;
    #2 reset = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_dout%0d", k), 32'(dout[k]), 32'h0);
      check_eq($sformatf("rst_irq%0d", k), 32'(irq[k]), 32'h0);
      check_eq($sformatf("rst_ready%0d", k), 32'(ready[k]), 32'h0);
      check_eq($sformatf("rst_rdata%0d", k), rdata[k], 32'h0);
    end
    @(negedge clock);
    check_eq("rst_no_ready", 32'(ready[0]), 32'h0);
    bus_valid = 1'b0; uart_data_in = 9'h0; reset = 1'b0;
    @(negedge clock);
    bus_op(1'b0, 4'h8, 32'h0, r0, r1);
    check_eq("post_rst_status0", r0, 32'h2);
    check_eq("post_rst_status1", r1, 32'h2);
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
